// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; a saturating streak counter lets a waiting fetch through.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    state_t            state_q;
    logic              mem_req_q, mem_we_q, if_ready_q, d_ready_q, busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic [3:0]        streak_q, streak_d;
    logic              grant_i, grant_d;

    // Fetch only beats a pending data request once data has had MAX_D_STREAK turns.
    always_comb begin
        grant_i  = if_req && (!d_req || streak_q == MAX_S);
        grant_d  = d_req && !grant_i;
        streak_d = 4'd0;
        if (if_req)
            streak_d = (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
            streak_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        busy_q      <= 1'b1;
                        streak_q    <= streak_d;
                        state_q     <= BUSY_D;
                    end else if (grant_i) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                        busy_q     <= 1'b1;
                        streak_q   <= 4'd0;
                        state_q    <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if_rdata_q <= mem_rdata;
                        if_ready_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        d_rdata_q <= mem_we_q ? '0 : mem_rdata;
                        d_ready_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          if_ready, d_ready, mem_req, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay cycles of mem_req, or once on spur_ack.
    logic [31:0] memarr [logic [31:0]];
    int          ack_delay;
    bit          spur_ack;
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (spur_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                spur_ack  = 1'b0;
                wcnt      = 0;
            end else if (mem_req === 1'b1) begin
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (mem_we === 1'b1) begin
                        memarr[mem_addr] = mem_wdata;
                        mem_rdata = 32'hFFFF_FFFF;  // garbage: stores must report 0
                    end else begin
                        mem_rdata = memarr.exists(mem_addr) ? memarr[mem_addr] : 32'h0;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Grant-order recorder.
    logic [31:0] grants[$];
    bit          rec;
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rec && mem_req === 1'b1 && !prev) grants.push_back(mem_addr);
            prev = (mem_req === 1'b1);
        end
    end

    // Reference model: one outstanding transaction record per grant.
    bit          m_valid, t_act, t_d, t_we, t_acked;
    int          streak;
    logic [31:0] e_addr, e_wdata, e_ifr, e_dr;
    initial begin
        m_valid = 0; t_act = 0; t_d = 0; t_we = 0; t_acked = 0; streak = 0;
        e_addr = 0; e_wdata = 0; e_ifr = 0; e_dr = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 1; t_act = 0; t_acked = 0; t_we = 0; streak = 0;
                e_addr = 0; e_wdata = 0; e_ifr = 0; e_dr = 0;
            end else if (t_act && t_acked) begin
                t_act = 0;
            end else if (t_act) begin
                if (mem_ack) begin
                    t_acked = 1;
                    if (t_d) e_dr = t_we ? 32'h0 : mem_rdata;
                    else     e_ifr = mem_rdata;
                end
            end else if (if_req || d_req) begin
                t_d     = d_req && !(if_req && streak == MAXS);
                t_act   = 1;
                t_acked = 0;
                if (t_d) begin
                    t_we    = d_we;
                    e_addr  = d_addr;
                    e_wdata = d_wdata;
                    streak  = if_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
                end else begin
                    t_we   = 0;
                    e_addr = if_addr;
                    streak = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("mdl_mem_req",  32'(mem_req),  32'(t_act && !t_acked));
                chk("mdl_mem_we",   32'(mem_we),   32'(t_act && !t_acked && t_we));
                chk("mdl_mem_addr", mem_addr,      e_addr);
                chk("mdl_mem_wdata", mem_wdata,    e_wdata);
                chk("mdl_if_ready", 32'(if_ready), 32'(t_act && t_acked && !t_d));
                chk("mdl_d_ready",  32'(d_ready),  32'(t_act && t_acked && t_d));
                chk("mdl_if_rdata", if_rdata,      e_ifr);
                chk("mdl_d_rdata",  d_rdata,       e_dr);
                chk("mdl_busy",     32'(busy),     32'(t_act));
            end
        end
    end

    task automatic wait_ready(input bit is_d, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if ((is_d ? d_ready : if_ready) === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s: ready not seen within 50 cycles, expected a pulse", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "timeout");
    end

    logic [31:0] exp_order [8];

    initial begin
        reset = 1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        ack_delay = 0; spur_ack = 0; rec = 0;
        memarr[32'h10]  = 32'hDEAD_BEEF;
        memarr[32'h40]  = 32'h0000_1234;
        memarr[32'h80]  = 32'h0000_FFFF;
        memarr[32'h300] = 32'h0000_0077;
        memarr[32'h304] = 32'h0000_0099;
        memarr[32'h1000] = 32'h1111_1111;
        memarr[32'h2000] = 32'h2222_2222;
        for (int i = 0; i < 8; i++) exp_order[i] = (i % 4 == 3) ? 32'h1000 : 32'h2000;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);

        // Fetch with immediate ack.
        reset = 0; if_req = 1; if_addr = 32'h10; ack_delay = 0;
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        @(negedge clk);
        chk("t1_if_ready", 32'(if_ready), 32'd1);
        chk("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("t1_model_ifr", e_ifr, 32'hDEAD_BEEF);
        if_req = 0;
        @(negedge clk);
        chk("t1_if_ready_off", 32'(if_ready), 32'd0);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd0);

        // Load whose address changes while in flight.
        d_req = 1; d_we = 0; d_addr = 32'h40; ack_delay = 2;
        @(negedge clk);
        chk("t4_mem_addr0", mem_addr, 32'h40);
        d_addr = 32'h80;
        repeat (2) begin
            @(negedge clk);
            chk("t4_mem_addr", mem_addr, 32'h40);
            chk("t4_mem_req", 32'(mem_req), 32'd1);
        end
        @(negedge clk);
        chk("t4_d_ready", 32'(d_ready), 32'd1);
        chk("t4_d_rdata", d_rdata, 32'h1234);
        d_req = 0;
        @(negedge clk);

        // Store with delayed ack.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55; ack_delay = 3;
        repeat (4) begin
            @(negedge clk);
            chk("t2_mem_we", 32'(mem_we), 32'd1);
            chk("t2_mem_wdata", mem_wdata, 32'h55);
            chk("t2_d_ready_early", 32'(d_ready), 32'd0);
        end
        @(negedge clk);
        chk("t2_d_ready", 32'(d_ready), 32'd1);
        chk("t2_d_rdata", d_rdata, 32'h0);
        chk("t2_if_ready", 32'(if_ready), 32'd0);
        chk("t2_model_dr", e_dr, 32'h0);
        d_req = 0; d_we = 0;
        repeat (2) @(negedge clk);

        // Load then fetch: each result register holds its own value.
        d_req = 1; d_we = 0; d_addr = 32'h300; ack_delay = 1;
        wait_ready(1, "t6_load");
        chk("t6_d_rdata", d_rdata, 32'h77);
        d_req = 0;
        @(negedge clk);
        if_req = 1; if_addr = 32'h304;
        wait_ready(0, "t6_fetch");
        chk("t6_if_rdata", if_rdata, 32'h99);
        chk("t6_d_rdata_held", d_rdata, 32'h77);
        if_req = 0;
        repeat (2) @(negedge clk);

        // Both requesters saturating: D,D,D,I repeating.
        if_addr = 32'h1000; d_addr = 32'h2000; d_we = 0; ack_delay = 0;
        grants.delete(); rec = 1;
        if_req = 1; d_req = 1;
        for (int i = 0; i < 200 && grants.size() < 8; i++) @(negedge clk);
        if_req = 0; d_req = 0; rec = 0;
        chk("t3_ngrants", 32'(grants.size()), 32'd8);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            chk($sformatf("t3_grant%0d", i), grants[i], exp_order[i]);
        repeat (6) @(negedge clk);

        // Reset in the middle of a fetch, then a stray ack.
        if_req = 1; if_addr = 32'h20; ack_delay = 10;
        repeat (3) @(negedge clk);
        chk("t5_busy_before", 32'(busy), 32'd1);
        reset = 1; if_req = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        spur_ack = 1;
        repeat (4) begin
            @(negedge clk);
            chk("t5_busy", 32'(busy), 32'd0);
            chk("t5_mem_req", 32'(mem_req), 32'd0);
            chk("t5_mem_addr", mem_addr, 32'h0);
            chk("t5_if_ready", 32'(if_ready), 32'd0);
            chk("t5_d_ready", 32'(d_ready), 32'd0);
            chk("t5_if_rdata", if_rdata, 32'h0);
            chk("t5_d_rdata", d_rdata, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
